// File: rtl/ifm_filter_fetch_responder.sv
// ifm_filter_fetch_responder: host-loaded IFM/filter word buffers answering
// paired read requests from the conv address generator with a fixed 2-cycle,
// in-order response pipeline and an end-of-pass drain pulse.
module ifm_filter_fetch_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IFM_DEPTH  = 1024,
  parameter int FLT_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr_ifm,
  input  logic [ADDR_WIDTH-1:0] req_addr_flt,
  input  logic                  pass_done,
  input  logic                  load_valid,
  input  logic                  load_sel,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_ifm,
  output logic [DATA_WIDTH-1:0] rsp_flt,
  output logic                  rsp_done,
  output logic [15:0]           req_count,
  output logic                  addr_err
);

  localparam int IFM_AW = $clog2(IFM_DEPTH);
  localparam int FLT_AW = $clog2(FLT_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] IFM_LIMIT = ADDR_WIDTH'(IFM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FLT_LIMIT = ADDR_WIDTH'(FLT_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SERVE,
    ST_DRAIN
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] ifm_mem [IFM_DEPTH];
  logic [DATA_WIDTH-1:0] flt_mem [FLT_DEPTH];

  logic [ADDR_WIDTH-1:0] ifm_widx;
  logic [ADDR_WIDTH-1:0] flt_widx;
  logic [ADDR_WIDTH-1:0] load_widx;
  logic                  ifm_ok;
  logic                  flt_ok;
  logic                  load_ok;
  logic                  req_err;
  logic                  load_err;
  logic                  accept;
  logic                  load_fire;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_ifm;
  logic [DATA_WIDTH-1:0] s1_flt;

  assign ifm_widx  = req_addr_ifm >> 2;
  assign flt_widx  = req_addr_flt >> 2;
  assign load_widx = load_addr >> 2;

  assign ifm_ok  = ifm_widx < IFM_LIMIT;
  assign flt_ok  = flt_widx < FLT_LIMIT;
  assign load_ok = load_sel ? (load_widx < FLT_LIMIT) : (load_widx < IFM_LIMIT);

  assign req_err  = (req_addr_ifm[1:0] != 2'b00) || (req_addr_flt[1:0] != 2'b00) ||
                    !ifm_ok || !flt_ok;
  assign load_err = (load_addr[1:0] != 2'b00) || !load_ok;

  assign accept     = req_valid && (state != ST_DRAIN);
  assign load_ready = ((state == ST_IDLE) || (state == ST_LOAD)) && !req_valid;
  assign load_fire  = load_valid && load_ready;

  // Host writes into the selected buffer; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (load_fire && load_ok) begin
      if (load_sel) begin
        flt_mem[load_widx[FLT_AW-1:0]] <= load_data;
      end else begin
        ifm_mem[load_widx[IFM_AW-1:0]] <= load_data;
      end
    end
  end

  // Two-stage response pipeline: stage 1 captures the buffer read, stage 2 drives outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_ifm    <= '0;
      s1_flt    <= '0;
      rsp_valid <= 1'b0;
      rsp_ifm   <= '0;
      rsp_flt   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ifm <= ifm_ok ? ifm_mem[ifm_widx[IFM_AW-1:0]] : '0;
        s1_flt <= flt_ok ? flt_mem[flt_widx[FLT_AW-1:0]] : '0;
      end
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_ifm <= s1_ifm;
        rsp_flt <= s1_flt;
      end
    end
  end

  // Pass control: load/serve/drain sequencing, request counting, sticky address error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_count <= '0;
      addr_err  <= 1'b0;
      rsp_done  <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (req_valid) begin
            state     <= ST_SERVE;
            req_count <= 16'd1;
            addr_err  <= req_err;
          end else if (load_valid) begin
            state <= ST_LOAD;
            if (load_err) addr_err <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (req_valid) begin
            if (req_count != '1) req_count <= req_count + 16'd1;
            if (req_err) addr_err <= 1'b1;
          end
          if (pass_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Stage 1 empty means stage 2 empties on this edge, so the pulse
          // lands in the cycle right after the final rsp_valid.
          if (!s1_valid) begin
            rsp_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_filter_fetch_responder.sv
// Testbench for ifm_filter_fetch_responder: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model (memories + expected-response queue).
module tb_ifm_filter_fetch_responder;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ID = 64;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr_ifm;
  logic [AW-1:0] req_addr_flt;
  logic          pass_done;
  logic          load_valid;
  logic          load_sel;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_ifm;
  logic [DW-1:0] rsp_flt;
  logic          rsp_done;
  logic [15:0]   req_count;
  logic          addr_err;

  ifm_filter_fetch_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IFM_DEPTH (ID),
    .FLT_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr_ifm(req_addr_ifm),
    .req_addr_flt(req_addr_flt),
    .pass_done   (pass_done),
    .load_valid  (load_valid),
    .load_sel    (load_sel),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ifm     (rsp_ifm),
    .rsp_flt     (rsp_flt),
    .rsp_done    (rsp_done),
    .req_count   (req_count),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] ifm;
    logic [31:0] flt;
  } rsp_t;

  logic [31:0] m_ifm [ID];
  logic [31:0] m_flt [FD];
  rsp_t        q[$];
  int          edge_n = 0;
  int          mode = 0;          // 0 = open for loads/new pass, 1 = serving, 2 = draining
  logic [15:0] m_count = '0;
  logic        m_err = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] hold_ifm = '0;
  logic [31:0] hold_flt = '0;

  function automatic logic [31:0] rd_ifm(input logic [31:0] a);
    int unsigned w = a >> 2;
    return (w < ID) ? m_ifm[w] : 32'd0;
  endfunction

  function automatic logic [31:0] rd_flt(input logic [31:0] a);
    int unsigned w = a >> 2;
    return (w < FD) ? m_flt[w] : 32'd0;
  endfunction

  function automatic logic bad_addr(input logic [31:0] a, input int depth);
    int unsigned w = a >> 2;
    return (a[1:0] != 2'b00) || (w >= depth);
  endfunction

  rsp_t        e;
  logic        rerr;
  logic        lerr;
  int unsigned lw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mode    = 0;
      m_count = '0;
      m_err   = 1'b0;
      m_done  = 1'b0;
    end else begin
      edge_n++;
      m_done = 1'b0;
      rerr = bad_addr(req_addr_ifm, ID) || bad_addr(req_addr_flt, FD);
      e.due = edge_n + 1;
      e.ifm = rd_ifm(req_addr_ifm);
      e.flt = rd_flt(req_addr_flt);
      case (mode)
        0: begin
          if (req_valid) begin
            q.push_back(e);
            m_count = 16'd1;
            m_err   = rerr;
            mode    = 1;
          end else if (load_valid) begin
            lerr = bad_addr(load_addr, load_sel ? FD : ID);
            lw   = load_addr >> 2;
            if (load_sel && lw < FD) m_flt[lw] = load_data;
            if (!load_sel && lw < ID) m_ifm[lw] = load_data;
            if (lerr) m_err = 1'b1;
          end
        end
        1: begin
          if (req_valid) begin
            q.push_back(e);
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            m_err = m_err | rerr;
          end
          if (pass_done) mode = 2;
        end
        default: begin
          if (q.size() == 0) begin
            m_done = 1'b1;
            mode   = 0;
          end
        end
      endcase
    end
  end

  // Compare every cycle against the model, away from the active edge.
  logic exp_v;
  always @(negedge clk) begin
    if (rst) begin
      hold_ifm = '0;
      hold_flt = '0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_done", rsp_done, 0);
      check("rst_req_count", req_count, 0);
      check("rst_addr_err", addr_err, 0);
      check("rst_rsp_ifm", rsp_ifm, 0);
      check("rst_rsp_flt", rsp_flt, 0);
    end else begin
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        exp_v    = 1'b1;
        hold_ifm = q[0].ifm;
        hold_flt = q[0].flt;
        void'(q.pop_front());
      end
      check("m_rsp_valid", rsp_valid, exp_v);
      check("m_rsp_ifm", rsp_ifm, hold_ifm);
      check("m_rsp_flt", rsp_flt, hold_flt);
      check("m_rsp_done", rsp_done, m_done);
      check("m_req_count", req_count, m_count);
      check("m_addr_err", addr_err, m_err);
      check("m_load_ready", load_ready, (mode == 0) && !req_valid);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_addr_ifm = '0;
    req_addr_flt = '0;
    pass_done    = 1'b0;
    load_valid   = 1'b0;
    load_sel     = 1'b0;
    load_addr    = '0;
    load_data    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic sel, input logic [31:0] a, input logic [31:0] d);
    idle_inputs();
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = a;
    load_data  = d;
    tick();
  endtask

  function automatic logic [31:0] rand_addr(input int depth);
    int r = $urandom_range(0, 19);
    if (r == 0) return 32'(4 * $urandom_range(0, depth - 1) + $urandom_range(1, 3));
    if (r == 1) return 32'(4 * $urandom_range(depth, depth + 4));
    return 32'(4 * $urandom_range(0, depth - 1));
  endfunction

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    @(negedge clk);
    check("reset_load_ready", load_ready, 1);
    tick();
    rst = 1'b0;

    // Fill both buffers, then the known pattern at the bottom.
    for (int i = 0; i < ID; i++) do_load(1'b0, 32'(4 * i), $urandom);
    for (int i = 0; i < FD; i++) do_load(1'b1, 32'(4 * i), $urandom);
    for (int i = 0; i < 16; i++) begin
      do_load(1'b0, 32'(4 * i), 32'(i + 100));
      do_load(1'b1, 32'(4 * i), 32'(i + 200));
    end
    idle_inputs();
    tick();

    // Burst of 16, pass_done on the last; requests during drain are ignored.
    for (int t = 0; t < 20; t++) begin
      idle_inputs();
      if (t < 18) begin
        req_valid    = 1'b1;
        req_addr_ifm = 32'(4 * t);
        req_addr_flt = 32'(4 * t);
      end
      pass_done = (t == 15);
      @(negedge clk);
      check("burst_valid", rsp_valid, (t >= 2 && t <= 17));
      if (t >= 2 && t <= 17) begin
        check("burst_ifm", rsp_ifm, 32'(100 + t - 2));
        check("burst_flt", rsp_flt, 32'(200 + t - 2));
      end
      check("burst_done", rsp_done, (t == 18));
      if (t == 18) check("burst_count", req_count, 16);
      tick();
    end

    // Load/request conflict in IDLE, load attempt in SERVE, gapped requests.
    for (int t = 0; t < 9; t++) begin
      idle_inputs();
      if (t == 0 || t == 2 || t == 3) begin
        req_valid    = 1'b1;
        req_addr_ifm = (t == 0) ? 32'd12 : (t == 2) ? 32'd20 : 32'd28;
        req_addr_flt = req_addr_ifm;
      end
      if (t <= 1) begin
        load_valid = 1'b1;
        load_addr  = '0;
        load_data  = 32'hDEADBEEF;
      end
      pass_done = (t == 5);
      @(negedge clk);
      if (t <= 1) check("conflict_load_ready", load_ready, 0);
      check("gap_valid", rsp_valid, (t == 2 || t == 4 || t == 5));
      if (t == 2) check("gap_ifm0", rsp_ifm, 103);
      if (t == 4) check("gap_ifm1", rsp_ifm, 105);
      if (t == 5) check("gap_flt2", rsp_flt, 207);
      tick();
    end

    // Word 0 must be untouched by the rejected loads.
    for (int t = 0; t < 5; t++) begin
      idle_inputs();
      if (t == 0) req_valid = 1'b1;
      pass_done = (t == 1);
      @(negedge clk);
      if (t == 2) begin
        check("noload_ifm0", rsp_ifm, 100);
        check("noload_flt0", rsp_flt, 200);
      end
      if (t == 3) check("single_done", rsp_done, 1);
      tick();
    end

    // Out-of-range read, misaligned load, error cleared by new pass.
    for (int t = 0; t < 13; t++) begin
      idle_inputs();
      if (t == 0) begin
        req_valid    = 1'b1;
        req_addr_ifm = 32'(4 * ID);
        req_addr_flt = 32'd4;
      end
      if (t == 1 || t == 8) pass_done = 1'b1;
      if (t == 5) begin
        load_valid = 1'b1;
        load_addr  = 32'h6;
        load_data  = 32'h55;
      end
      if (t == 7) begin
        req_valid    = 1'b1;
        req_addr_ifm = 32'd4;
        req_addr_flt = 32'd4;
      end
      @(negedge clk);
      if (t == 1) check("oor_err", addr_err, 1);
      if (t == 2) begin
        check("oor_ifm", rsp_ifm, 0);
        check("oor_flt", rsp_flt, 201);
        check("oor_err_drain", addr_err, 1);
      end
      if (t == 3) check("oor_done", rsp_done, 1);
      if (t == 6) check("misalign_err", addr_err, 1);
      if (t == 8) check("newpass_err_clr", addr_err, 0);
      if (t == 9) check("misalign_word1", rsp_ifm, 32'h55);
      tick();
    end

    // Reset mid-pass with two requests in flight.
    for (int t = 0; t < 14; t++) begin
      idle_inputs();
      if (t <= 1 || t == 8) begin
        req_valid    = 1'b1;
        req_addr_ifm = (t == 0) ? 32'd8 : (t == 1) ? 32'd12 : 32'd8;
        req_addr_flt = req_addr_ifm;
      end
      rst = (t == 2 || t == 3);
      pass_done = (t == 9);
      @(negedge clk);
      if (t >= 2 && t <= 7) begin
        check("midrst_valid", rsp_valid, 0);
        check("midrst_done", rsp_done, 0);
        check("midrst_count", req_count, 0);
      end
      if (t == 10) begin
        check("postrst_ifm2", rsp_ifm, 102);
        check("postrst_flt2", rsp_flt, 202);
      end
      tick();
    end
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        continue;
      end
      req_valid    = ($urandom_range(0, 99) < 45);
      req_addr_ifm = rand_addr(ID);
      req_addr_flt = rand_addr(FD);
      pass_done    = ($urandom_range(0, 19) == 0);
      load_valid   = ($urandom_range(0, 2) == 0);
      load_sel     = 1'($urandom_range(0, 1));
      load_addr    = rand_addr(load_sel ? FD : ID);
      load_data    = $urandom;
      tick();
    end
    idle_inputs();
    pass_done = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
